// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad key reader.
//   - key-code constants used by the scanner link
//   - debounce FSM state type
//   - is_valid_key(): true for the digit/'*'/'#' codes 0..11
//   - max_int(): elaboration-time helper for sizing counters
package keypad_pkg;

  localparam logic [3:0] KEY_STAR      = 4'd10;
  localparam logic [3:0] KEY_HASH      = 4'd11;
  localparam logic [3:0] KEY_SCAN_HOLD = 4'd13;
  localparam logic [3:0] KEY_NONE      = 4'd15;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kr_state_e;

  function automatic logic is_valid_key(input logic [3:0] code);
    return code <= KEY_HASH;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_key_reader_fifo.sv
// key_fifo: parameterised synchronous FIFO holding accepted key codes.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, data_i      write request and data (dropped when full unless a pop frees a slot)
//   pop_i               read request (ignored when empty)
//   head_o              head entry, EMPTY_VAL when empty
//   empty_o, full_o     occupancy flags
//   count_o             current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module key_fifo #(
  parameter int              DEPTH     = 8,
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop makes room, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o  = empty_o ? EMPTY_VAL : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/keypad_key_reader.sv
// keypad_key_reader: consumer end of the keypad scanner link.
// Synchronises the scanner code, debounces press and release, queues one
// event per press in key_fifo and acknowledges each stored key.
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   buttonPressed       async scanner code (0..11 keys, 12..15 no key)
//   key_pop             pop FIFO head
//   clr_overflow        clear sticky overflow
//   key_valid/key_code  FIFO head view (key_code = 4'hF when empty)
//   key_count           FIFO occupancy
//   overflow            sticky: a key was dropped on a full FIFO
//   acknowledgeKey      bit0 pulses one cycle per stored key
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while held).
//
// state      | meaning
// IDLE       | no key, waiting for a valid sample
// PRESS_DB   | counting identical samples of cand
// HELD       | key accepted, waiting for release
// RELEASE_DB | counting no-key samples before re-arming
module keypad_key_reader
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES  = 500000,
  parameter int RELEASE_CYCLES = 500000,
  parameter int DEPTH          = 8,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             buttonPressed,
  input  logic                   key_pop,
  input  logic                   clr_overflow,
  output logic                   key_valid,
  output logic [3:0]             key_code,
  output logic [$clog2(DEPTH):0] key_count,
  output logic                   overflow,
  output logic [31:0]            acknowledgeKey
);
  localparam int CNT_MAX = max_int(max_int(STABLE_CYCLES, RELEASE_CYCLES),
                                   max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] STABLE_C  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] RELEASE_C = CW'(RELEASE_CYCLES);

  logic [3:0]  sync1_q, sync2_q, sample;
  logic        sample_valid;
  kr_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  cand_q, cand_d;
  logic        press_push, rep_push, push;
  logic        fifo_empty, fifo_full, stored;
  logic        ack_q, ovf_q;

  assign sample       = sync2_q;
  assign sample_valid = is_valid_key(sample);
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= KEY_NONE;
      sync2_q <= KEY_NONE;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
    end else begin
      sync1_q <= buttonPressed;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = PRESS_DB;
          cand_d  = sample;
          cnt_d   = CW'(1);
        end
      end
      PRESS_DB: begin
        if (sample != cand_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= STABLE_C) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!sample_valid) begin
          state_d = RELEASE_DB;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_DB: begin
        if (sample_valid) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= RELEASE_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    press_push = (state_q == PRESS_DB) && (sample == cand_q) && (cnt_inc >= STABLE_C);
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_PERIOD_C = CW'(REPEAT_PERIOD);
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;

  // rep_cnt holds the number of HELD cycles elapsed since entry or last repeat.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    if (state_q != HELD && state_d == HELD) begin
      rep_cnt_d   = CW'(1);
      rep_first_d = 1'b1;
    end else if (state_q == HELD && state_d == HELD) begin
      if (rep_cnt_q == (rep_first_q ? REP_DELAY_C : REP_PERIOD_C)) begin
        rep_push    = 1'b1;
        rep_cnt_d   = CW'(1);
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  assign push   = press_push || rep_push;
  assign stored = push && (!fifo_full || (key_pop && !fifo_empty));

  key_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (4),
    .EMPTY_VAL (KEY_NONE)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (cand_q),
    .pop_i   (key_pop),
    .head_o  (key_code),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (key_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= stored;
      if (push && !stored) ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign key_valid      = !fifo_empty;
  assign overflow       = ovf_q;
  assign acknowledgeKey = {31'b0, ack_q};

endmodule

// File: tb/tb_keypad_key_reader.sv
module tb_keypad_key_reader;
  localparam int STABLE = 4, RELEASE = 4, DEPTH = 4, RDELAY = 20, RPERIOD = 8;

  logic clock = 1'b0;
  logic reset;
  logic [3:0] buttonPressed;
  logic key_pop, clr_overflow;
  logic key_valid;
  logic [3:0] key_code;
  logic [$clog2(DEPTH):0] key_count;
  logic overflow;
  logic [31:0] acknowledgeKey;

  always #5 clock = ~clock;

  keypad_key_reader #(
    .STABLE_CYCLES(STABLE), .RELEASE_CYCLES(RELEASE), .DEPTH(DEPTH),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clock(clock), .reset(reset), .buttonPressed(buttonPressed),
    .key_pop(key_pop), .clr_overflow(clr_overflow),
    .key_valid(key_valid), .key_code(key_code), .key_count(key_count),
    .overflow(overflow), .acknowledgeKey(acknowledgeKey)
  );

  int tests = 0, fails = 0, cyc = 0, ack_seen = 0;
  bit started = 0;
  int         exp_ack_q[$];
  logic [3:0] exp_code_q[$];

  // Reference model: behaviour of the synchronised sample stream.
  logic [3:0] d1 = 4'hF, d2 = 4'hF, cand = 4'hF;
  bit held = 0, pending = 0, rep_first = 1, m_ovf = 0;
  int n = 0, quiet = 0, age = 0;
  logic [3:0] mfifo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [3:0] in, input bit pop, input bit clr, input bit rst);
    logic [3:0] s;
    bit attempt, valid;
    if (rst) begin
      d1 = 4'hF; d2 = 4'hF; held = 0; pending = 0; n = 0; quiet = 0; age = 0;
      m_ovf = 0; mfifo.delete(); exp_code_q.delete(); exp_ack_q.delete();
      return;
    end
    s = d2; d2 = d1; d1 = in;
    valid = (s < 4'd12);
    attempt = 0;
    if (!held) begin
      if (pending && s == cand) begin
        n++;
        if (n >= STABLE) begin
          attempt = 1; held = 1; pending = 0; quiet = 0; age = 0; rep_first = 1;
        end
      end else if (pending) begin
        pending = 0; n = 0;
      end else if (valid) begin
        pending = 1; cand = s; n = 1;
      end
    end else if (!valid) begin
      quiet++;
      if (quiet >= RELEASE) held = 0;
    end else if (quiet > 0) begin
      quiet = 0; age = 0; rep_first = 1;
    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
      age++;
      if (age == (rep_first ? RDELAY : RPERIOD)) begin
        attempt = 1; age = 0; rep_first = 0;
      end
`endif
    end
    if (pop && mfifo.size() > 0) void'(mfifo.pop_front());
    if (attempt && mfifo.size() < DEPTH) begin
      mfifo.push_back(cand);
      exp_code_q.push_back(cand);
      exp_ack_q.push_back(cyc);
    end else if (attempt) begin
      m_ovf = 1;
    end else if (clr) begin
      m_ovf = 0;
    end
  endtask

  task automatic step(input logic [3:0] code, input bit pop, input bit clr, input bit rst);
    buttonPressed = code; key_pop = pop; clr_overflow = clr; reset = rst;
    @(posedge clock);
    cyc++;
    model_step(code, pop, clr, rst);
    if (rst) started = 1;
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    repeat (hold) step(code, 0, 0, 0);
    repeat (rel) step(4'hF, 0, 0, 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    int e;
    if (started) begin
      check("key_count", 32'(key_count), 32'(mfifo.size()));
      check("key_valid", 32'(key_valid), 32'(mfifo.size() > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (mfifo.size() == 0) check("empty_code", 32'(key_code), 32'hF);
      if (acknowledgeKey !== 32'h0) begin
        ack_seen++;
        check("ack_word", acknowledgeKey, 32'h1);
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_ack_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e));
        end
      end else if (exp_ack_q.size() > 0 && exp_ack_q[0] <= cyc) begin
        e = exp_ack_q.pop_front();
        check("ack_missing", 32'(0), 32'(1));
      end
      if (key_pop && key_valid) begin
        if (exp_code_q.size() == 0) check("pop_unexpected", 32'(key_code), 32'hF);
        else check("pop_code", 32'(key_code), 32'(exp_code_q.pop_front()));
      end
    end
  end

  initial begin
    int a0, dur, nrep;
    logic [3:0] code;
    buttonPressed = 4'hF; key_pop = 0; clr_overflow = 0; reset = 1;
    step(4'hF, 0, 0, 1);
    step(4'hF, 0, 0, 1);
    check("rst_valid", 32'(key_valid), 32'(0));
    check("rst_code", 32'(key_code), 32'hF);
    check("rst_count", 32'(key_count), 32'(0));
    check("rst_ack", acknowledgeKey, 32'h0);
    check("rst_ovf", 32'(overflow), 32'(0));

    // Single clean press
    a0 = ack_seen;
    press(4'd5, 10, 10);
    check("t1_acks", 32'(ack_seen - a0), 32'(1));
    check("t1_valid", 32'(key_valid), 32'(1));
    check("t1_code", 32'(key_code), 32'(5));
    step(4'hF, 1, 0, 0);

    // Too-short glitches
    a0 = ack_seen;
    press(4'd7, 2, 1);
    press(4'd7, 2, 10);
    check("t2_acks", 32'(ack_seen - a0), 32'(0));
    check("t2_count", 32'(key_count), 32'(0));

    // Release bounce
    a0 = ack_seen;
    press(4'd3, 6, 2);
    press(4'd3, 6, 10);
    check("t3_acks", 32'(ack_seen - a0), 32'(1));
    step(4'hF, 1, 0, 0);

    // Overflow
    step(4'hF, 0, 0, 1);
    a0 = ack_seen;
    for (int k = 1; k <= 5; k++) press(4'(k), 6, 8);
    check("t4_acks", 32'(ack_seen - a0), 32'(4));
    check("t4_count", 32'(key_count), 32'(4));
    check("t4_ovf", 32'(overflow), 32'(1));
    for (int k = 1; k <= 4; k++) begin
      check("t4_head", 32'(key_code), 32'(k));
      step(4'hF, 1, 0, 0);
    end
    step(4'hF, 1, 0, 0);
    check("t4_empty_pop", 32'(key_count), 32'(0));

    // Full FIFO, push and pop on the same edge
    step(4'hF, 0, 0, 1);
    a0 = ack_seen;
    for (int k = 1; k <= 4; k++) press(4'(k), 6, 8);
    for (int i = 0; i < 8; i++) step(4'd6, i == 5, 0, 0);
    check("t5_acks", 32'(ack_seen - a0), 32'(5));
    check("t5_count", 32'(key_count), 32'(4));
    check("t5_ovf", 32'(overflow), 32'(0));
    check("t5_head", 32'(key_code), 32'(2));
    press(4'hF, 0, 10);
    repeat (5) step(4'hF, 1, 0, 0);

    // Long hold
    step(4'hF, 0, 0, 1);
    a0 = ack_seen;
    press(4'd9, 36, 10);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("t6_acks", 32'(ack_seen - a0), 32'(3));
`else
    check("t6_acks", 32'(ack_seen - a0), 32'(1));
`endif
    repeat (5) step(4'hF, 1, 0, 0);

    // Randomised traffic against the model
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(12, 15));
      else code = 4'($urandom_range(0, 11));
      dur = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(1, 9);
      nrep = dur;
      for (int i = 0; i < nrep; i++)
        step(code, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 999) == 0);
    end

    repeat (20) step(4'hF, 1, 0, 0);
    check("drain_ack", 32'(exp_ack_q.size()), 32'(0));
    check("drain_code", 32'(exp_code_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
